// File: rtl/pad_gpio_bank.sv
// rtl/pad_gpio_bank.sv - GPIO bank: OUT/OE pad drive, synchronised inputs, edge-capture level IRQ
// Define GPIO_DEBOUNCE_EN to add the per-pad debounce counters and the DB_LIMIT register.
module pad_gpio_bank #(
    parameter int NUM_PADS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          reg_addr,
    input  logic                reg_we,
    input  logic                reg_re,
    input  logic [31:0]         reg_wdata,
    output logic [31:0]         reg_rdata,
    input  logic [NUM_PADS-1:0] pad_in,
    output logic [NUM_PADS-1:0] pad_out,
    output logic [NUM_PADS-1:0] pad_oe,
    output logic                irq
);

    logic [NUM_PADS-1:0]   r_out, r_oe, r_irq_en, r_stat, r_edge_rise, r_edge_fall, r_prev;
    logic [NUM_PADS-1:0]   r_sync [SYNC_STAGES];
    logic [31:0]           r_rdata;
    logic                  r_irq;
    logic [NUM_PADS-1:0]   w_synced, w_stable, w_rise, w_fall, w_clr, w_set;
    logic [DEBOUNCE_W-1:0] w_db_limit;
    logic [31:0]           w_rd_mux;
    logic                  w_unused;

    assign w_unused  = &{1'b0, reg_wdata};
    assign pad_out   = r_out;
    assign pad_oe    = r_oe;
    assign reg_rdata = r_rdata;
    assign irq       = r_irq;
    assign w_synced  = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= pad_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [DEBOUNCE_W-1:0] r_db_limit;
    logic [DEBOUNCE_W-1:0] r_cnt [NUM_PADS];
    logic [NUM_PADS-1:0]   r_stable;

    // A pad commits only after differing for DB_LIMIT+1 consecutive compares.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= '0;
            for (int p = 0; p < NUM_PADS; p++) r_cnt[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PADS; p++) begin
                if (w_synced[p] == r_stable[p]) begin
                    r_cnt[p] <= '0;
                end else if (r_cnt[p] == r_db_limit) begin
                    r_stable[p] <= w_synced[p];
                    r_cnt[p]    <= '0;
                end else begin
                    r_cnt[p] <= r_cnt[p] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_db_limit <= '0;
        else if (reg_we && reg_addr == 3'd7) r_db_limit <= reg_wdata[DEBOUNCE_W-1:0];
    end

    assign w_stable   = r_stable;
    assign w_db_limit = r_db_limit;
`else
    assign w_stable   = w_synced;
    assign w_db_limit = '0;
`endif

    assign w_rise = w_stable & ~r_prev;
    assign w_fall = ~w_stable & r_prev;
    assign w_set  = (w_rise & r_edge_rise) | (w_fall & r_edge_fall);
    assign w_clr  = (reg_we && reg_addr == 3'd4) ? reg_wdata[NUM_PADS-1:0] : '0;

    always_comb begin
        w_rd_mux = '0;
        case (reg_addr)
            3'd0:    w_rd_mux = 32'(r_out);
            3'd1:    w_rd_mux = 32'(r_oe);
            3'd2:    w_rd_mux = 32'(w_stable);
            3'd3:    w_rd_mux = 32'(r_irq_en);
            3'd4:    w_rd_mux = 32'(r_stat);
            3'd5:    w_rd_mux = 32'(r_edge_rise);
            3'd6:    w_rd_mux = 32'(r_edge_fall);
            3'd7:    w_rd_mux = 32'(w_db_limit);
            default: w_rd_mux = '0;
        endcase
    end

    // Set terms are ORed after the clear so a same-cycle capture survives W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_oe        <= '0;
            r_irq_en    <= '0;
            r_stat      <= '0;
            r_edge_rise <= '0;
            r_edge_fall <= '0;
            r_prev      <= '0;
            r_rdata     <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_prev <= w_stable;
            r_stat <= (r_stat & ~w_clr) | w_set;
            r_irq  <= |(r_stat & r_irq_en);
            if (reg_re) r_rdata <= w_rd_mux;
            if (reg_we) begin
                case (reg_addr)
                    3'd0:    r_out       <= reg_wdata[NUM_PADS-1:0];
                    3'd1:    r_oe        <= reg_wdata[NUM_PADS-1:0];
                    3'd3:    r_irq_en    <= reg_wdata[NUM_PADS-1:0];
                    3'd5:    r_edge_rise <= reg_wdata[NUM_PADS-1:0];
                    3'd6:    r_edge_fall <= reg_wdata[NUM_PADS-1:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pad_gpio_bank.sv
// tb/tb_pad_gpio_bank.sv - self-checking bench for pad_gpio_bank against a behavioural reference model
module tb_pad_gpio_bank;

    localparam int N = 8;
    localparam int S = 2;
    localparam int W = 8;
`ifdef GPIO_DEBOUNCE_EN
    localparam int DB0 = 1;
`else
    localparam int DB0 = 0;
`endif
    localparam int LAT = S + DB0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    reg_addr = '0;
    logic          reg_we = 1'b0;
    logic          reg_re = 1'b0;
    logic [31:0]   reg_wdata = '0;
    logic [N-1:0]  pad_in = '0;
    logic [31:0]   reg_rdata;
    logic [N-1:0]  pad_out, pad_oe;
    logic          irq;

    int n_vec = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    pad_gpio_bank #(.NUM_PADS(N), .SYNC_STAGES(S), .DEBOUNCE_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .reg_addr(reg_addr), .reg_we(reg_we), .reg_re(reg_re),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .pad_in(pad_in), .pad_out(pad_out),
        .pad_oe(pad_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: register file, input history queue and per-pad run lengths.
    logic [N-1:0] m_out = '0, m_oe = '0, m_ie = '0, m_stat = '0;
    logic [N-1:0] m_er = '0, m_ef = '0, m_prev = '0, m_stable = '0;
    logic [W-1:0] m_lim = '0;
    logic [31:0]  m_rdata = '0;
    logic         m_irq = 1'b0;
    logic [N-1:0] m_hist[$];
    int           m_run[N];

    task automatic model_reset();
        m_out = '0; m_oe = '0; m_ie = '0; m_stat = '0; m_er = '0; m_ef = '0;
        m_prev = '0; m_stable = '0; m_lim = '0; m_rdata = '0; m_irq = 1'b0;
        m_hist.delete();
        repeat (S) m_hist.push_back('0);
        for (int p = 0; p < N; p++) m_run[p] = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] syn, stb, clr, nstat;
        syn = m_hist[S-1];
`ifdef GPIO_DEBOUNCE_EN
        stb = m_stable;
`else
        stb = syn;
`endif
        clr = (reg_we && reg_addr == 3'd4) ? reg_wdata[N-1:0] : '0;
        nstat = (m_stat & ~clr) | (stb & ~m_prev & m_er) | (~stb & m_prev & m_ef);
        m_irq = |(m_stat & m_ie);
        if (reg_re) begin
            case (reg_addr)
                3'd0: m_rdata = 32'(m_out);
                3'd1: m_rdata = 32'(m_oe);
                3'd2: m_rdata = 32'(stb);
                3'd3: m_rdata = 32'(m_ie);
                3'd4: m_rdata = 32'(m_stat);
                3'd5: m_rdata = 32'(m_er);
                3'd6: m_rdata = 32'(m_ef);
                default: m_rdata = DB0 ? 32'(m_lim) : 32'd0;
            endcase
        end
`ifdef GPIO_DEBOUNCE_EN
        for (int p = 0; p < N; p++) begin
            if (syn[p] != m_stable[p]) begin
                m_run[p]++;
                if (m_run[p] > int'(m_lim)) begin
                    m_stable[p] = syn[p];
                    m_run[p] = 0;
                end
            end else begin
                m_run[p] = 0;
            end
        end
`endif
        if (reg_we) begin
            case (reg_addr)
                3'd0: m_out = reg_wdata[N-1:0];
                3'd1: m_oe  = reg_wdata[N-1:0];
                3'd3: m_ie  = reg_wdata[N-1:0];
                3'd5: m_er  = reg_wdata[N-1:0];
                3'd6: m_ef  = reg_wdata[N-1:0];
                3'd7: if (DB0 != 0) m_lim = reg_wdata[W-1:0];
                default: ;
            endcase
        end
        m_stat = nstat;
        m_prev = stb;
        m_hist.push_front(pad_in);
        m_hist.delete(S);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cyc_pad_out", 32'(pad_out), 32'(m_out));
                check("cyc_pad_oe", 32'(pad_oe), 32'(m_oe));
                check("cyc_irq", 32'(irq), 32'(m_irq));
                check("cyc_rdata", reg_rdata, m_rdata);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        reg_addr = a; reg_wdata = d; reg_we = 1'b1;
        @(negedge clk);
        reg_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
        reg_addr = a; reg_re = 1'b1;
        @(negedge clk);
        reg_re = 1'b0;
        check(nm, reg_rdata, exp);
    endtask

    logic [N-1:0] tbl [5];

    initial begin
        tbl[0] = 8'h03; tbl[1] = 8'h02; tbl[2] = 8'h12; tbl[3] = 8'h10; tbl[4] = 8'h10;
        repeat (3) tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("rst_pad_oe", 32'(pad_oe), 32'h0);
        check("rst_pad_out", 32'(pad_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, $sformatf("rst_rd%0d", a));

        wr(3'd0, 32'hFFFF_FFA5);
        check("out_a5", 32'(pad_out), 32'hA5);
        wr(3'd1, 32'h0000_000F);
        check("oe_0f", 32'(pad_oe), 32'h0F);
        rd(3'd0, 32'hA5, "rd_out");
        rd(3'd1, 32'h0F, "rd_oe");
        wr(3'd2, 32'hFF);
        rd(3'd2, 32'h0, "rd_in_ro");
        wr(3'd7, 32'h155);
        rd(3'd7, DB0 ? 32'h55 : 32'h0, "rd_db_limit");
        wr(3'd7, 32'h0);

        #2 rst_n = 1'b0;
        #1 check("midrst_pad_oe", 32'(pad_oe), 32'h0);
        check("midrst_pad_out", 32'(pad_out), 32'h0);
        tick();
        rst_n = 1'b1;
        rd(3'd1, 32'h0, "midrst_rd_oe");

        // Rising-edge latency on pad 0
        wr(3'd5, 32'h01);
        wr(3'd3, 32'h01);
        pad_in[0] = 1'b1;
        for (int k = 1; k <= LAT + 2; k++) begin
            if (k == LAT + 1) begin reg_addr = 3'd2; reg_re = 1'b1; end
            if (k == LAT + 2) reg_addr = 3'd4;
            tick();
            check($sformatf("lat_irq_e%0d", k), 32'(irq), 32'(k >= LAT + 2));
            if (k == LAT + 1) check("lat_in", reg_rdata, 32'h01);
            if (k == LAT + 2) begin check("lat_stat", reg_rdata, 32'h01); reg_re = 1'b0; end
        end
        wr(3'd4, 32'h01);
        check("w1c_irq_hold", 32'(irq), 32'h1);
        tick();
        check("w1c_irq_clr", 32'(irq), 32'h0);

        // Falling-edge select on pad 7
        wr(3'd3, 32'h0);
        wr(3'd6, 32'h80);
        pad_in[7] = 1'b1;
        repeat (LAT + 3) tick();
        rd(3'd4, 32'h0, "fall_no_rise");
        pad_in[7] = 1'b0;
        repeat (LAT + 3) tick();
        rd(3'd4, 32'h80, "fall_stat");
        check("fall_irq_masked", 32'(irq), 32'h0);
        wr(3'd3, 32'h80);
        check("fall_irq_en_edge", 32'(irq), 32'h0);
        tick();
        check("fall_irq_set", 32'(irq), 32'h1);
        wr(3'd4, 32'h80);
        wr(3'd3, 32'h0);
        wr(3'd6, 32'h0);

        // W1C landing on the same edge as a new capture
        pad_in[0] = 1'b0;
        repeat (LAT + 3) tick();
        pad_in[0] = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            if (k == LAT + 1) begin reg_addr = 3'd4; reg_wdata = 32'h01; reg_we = 1'b1; end
            tick();
        end
        reg_we = 1'b0;
        rd(3'd4, 32'h01, "set_wins");
        wr(3'd4, 32'hFF);

        // Both edges on all pads over a directed sequence
        wr(3'd5, 32'hFF);
        wr(3'd6, 32'hFF);
        wr(3'd3, 32'hFF);
        for (int i = 0; i < 5; i++) begin
            pad_in = tbl[i];
            repeat (2) tick();
        end
        repeat (LAT + 3) tick();
        rd(3'd4, 32'h13, "seq_stat");
        check("seq_irq", 32'(irq), 32'h1);
        rd(3'd2, 32'h10, "seq_in");
        wr(3'd5, 32'h0);
        wr(3'd6, 32'h0);
        wr(3'd3, 32'h0);
        wr(3'd4, 32'hFF);

`ifdef GPIO_DEBOUNCE_EN
        pad_in = '0;
        repeat (8) tick();
        wr(3'd4, 32'hFF);
        wr(3'd7, 32'h3);
        rd(3'd7, 32'h3, "db_limit_rd");
        wr(3'd5, 32'h04);
        wr(3'd3, 32'h04);
        pad_in[2] = 1'b1;
        repeat (3) tick();
        pad_in[2] = 1'b0;
        repeat (10) tick();
        rd(3'd2, 32'h0, "db_glitch_in");
        rd(3'd4, 32'h0, "db_glitch_stat");
        pad_in[2] = 1'b1;
        for (int k = 1; k <= S + 6; k++) begin
            tick();
            check($sformatf("db_irq_e%0d", k), 32'(irq), 32'(k >= S + 6));
        end
        rd(3'd2, 32'h04, "db_held_in");
        rd(3'd4, 32'h04, "db_held_stat");
`endif

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
